// File: rtl/wb_regfile.sv
// wb_regfile: write-back result select, register file with bypassed reads, debug read and retire stats
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [CNT_W-1:0]  WbCount,
    output logic [ADDR_W-1:0] WbLastReg
);
    localparam int N = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              wr_en;

    // result select, commit enable and next-state of array and stats
    always_comb begin
        ResultW = MemtoRegW ? ReadDataW : ALUOutW;
        wr_en   = RegWriteW && (WriteRegW != '0);
        regs_d  = regs_q;
        if (wr_en) regs_d[WriteRegW] = ResultW;
        regs_d[0] = '0;
        cnt_d   = wr_en ? cnt_q + CNT_W'(1) : cnt_q;
        last_d  = wr_en ? WriteRegW : last_q;
    end

    // read ports; register 0 reads zero and bypass makes a same-cycle write visible
    always_comb begin
        RD1       = (A1 == '0) ? '0 : (BYPASS != 0 && wr_en && A1 == WriteRegW) ? ResultW : regs_q[A1];
        RD2       = (A2 == '0) ? '0 : (BYPASS != 0 && wr_en && A2 == WriteRegW) ? ResultW : regs_q[A2];
        DbgData   = regs_q[DbgAddr];
        WbCount   = cnt_q;
        WbLastReg = last_q;
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized check of wb_regfile against a register-array reference model
module tb_wb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 0, rst_n = 1, run = 0, chk_on = 0;
    logic          RegWriteW = 0, MemtoRegW = 0;
    logic [DW-1:0] ALUOutW = 0, ReadDataW = 0;
    logic [AW-1:0] WriteRegW = 0, A1 = 0, A2 = 0, DbgAddr = 0;
    logic [DW-1:0] RD1, RD2, ResultW, DbgData;
    logic [CW-1:0] WbCount;
    logic [AW-1:0] WbLastReg;
    logic [DW-1:0] n_RD1, n_RD2, n_Res, n_Dbg;
    logic [CW-1:0] n_Cnt;
    logic [AW-1:0] n_Last;

    int passed = 0, total = 0;

    logic [DW-1:0] m [2**AW];
    int            cnt;
    logic [AW-1:0] last;

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
        .DbgAddr(DbgAddr), .DbgData(DbgData), .WbCount(WbCount), .WbLastReg(WbLastReg)
    );

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(n_RD1), .RD2(n_RD2), .ResultW(n_Res),
        .DbgAddr(DbgAddr), .DbgData(n_Dbg), .WbCount(n_Cnt), .WbLastReg(n_Last)
    );

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    function automatic logic [DW-1:0] exp_res();
        return MemtoRegW ? ReadDataW : ALUOutW;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && RegWriteW && WriteRegW != 0 && a == WriteRegW) return exp_res();
        return m[a];
    endfunction

    task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: architectural state as an array plus a modular retire count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m[i]) m[i] <= '0;
            cnt  <= 0;
            last <= '0;
        end else if (RegWriteW && WriteRegW != 0) begin
            m[WriteRegW] <= exp_res();
            cnt  <= (cnt + 1) % (1 << CW);
            last <= WriteRegW;
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("ResultW", ResultW, exp_res());
            chk("RD1", RD1, exp_rd(A1, 1));
            chk("RD2", RD2, exp_rd(A2, 1));
            chk("DbgData", DbgData, m[DbgAddr]);
            chk("WbCount", DW'(WbCount), DW'(cnt));
            chk("WbLastReg", DW'(WbLastReg), DW'(last));
            chk("nb_RD1", n_RD1, exp_rd(A1, 0));
            chk("nb_RD2", n_RD2, exp_rd(A2, 0));
            chk("nb_Dbg", n_Dbg, m[DbgAddr]);
            chk("nb_WbCount", DW'(n_Cnt), DW'(cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        A1 = 7; A2 = 7; DbgAddr = 7;
        #1 rst_n = 0;
        #1;
        chk("rst_RD1", RD1, 0);
        chk("rst_RD2", RD2, 0);
        chk("rst_Dbg", DbgData, 0);
        chk("rst_Cnt", DW'(WbCount), 0);
        chk("rst_Last", DW'(WbLastReg), 0);
        #3 rst_n = 1;
        run = 1;
        chk_on = 1;

        RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'h1234_5678; WriteRegW = 5; DbgAddr = 5;
        tick();
        RegWriteW = 0;
        #1;
        chk("wr_Dbg5", DbgData, 32'h1234_5678);
        chk("wr_Cnt", DW'(WbCount), 1);
        chk("wr_Last", DW'(WbLastReg), 5);

        RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'hDEAD_BEEF; WriteRegW = 9;
        A1 = 9; A2 = 9; DbgAddr = 9;
        #1;
        chk("byp_RD1", RD1, 32'hDEAD_BEEF);
        chk("byp_RD2", RD2, 32'hDEAD_BEEF);
        chk("byp_Dbg_old", DbgData, 0);
        chk("nobyp_RD1_old", n_RD1, 0);
        tick();
        RegWriteW = 0;
        #1;
        chk("byp_Dbg_new", DbgData, 32'hDEAD_BEEF);
        chk("nobyp_RD1_new", n_RD1, 32'hDEAD_BEEF);

        RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'hFFFF_FFFF; WriteRegW = 0; A1 = 0; DbgAddr = 0;
        #1;
        chk("z_RD1_pre", RD1, 0);
        chk("z_Res", ResultW, 32'hFFFF_FFFF);
        tick();
        chk("z_RD1_post", RD1, 0);
        chk("z_Dbg", DbgData, 0);
        chk("z_Cnt", DW'(WbCount), 2);

        for (int i = 0; i < 13; i++) begin
            RegWriteW = 1; WriteRegW = AW'((i % 31) + 1); ALUOutW = $urandom;
            tick();
        end
        RegWriteW = 0;
        #1;
        chk("wrap_15", DW'(WbCount), 15);
        RegWriteW = 1; WriteRegW = 20;
        tick();
        RegWriteW = 0;
        #1;
        chk("wrap_0", DW'(WbCount), 0);

        repeat (400) begin
            RegWriteW = ($urandom % 4) != 0;
            MemtoRegW = $urandom % 2;
            ALUOutW   = $urandom;
            ReadDataW = $urandom;
            WriteRegW = AW'($urandom);
            case ($urandom % 4)
                0: A1 = WriteRegW;
                1: A1 = 0;
                default: A1 = AW'($urandom);
            endcase
            A2 = ($urandom % 3 == 0) ? A1 : AW'($urandom);
            DbgAddr = AW'($urandom);
            tick();
        end

        RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'hCAFE_0003; WriteRegW = 3; DbgAddr = 3; A1 = 0; A2 = 0;
        tick();
        chk("ar_pre", DbgData, 32'hCAFE_0003);
        #2 rst_n = 0;
        #1;
        chk("ar_Dbg", DbgData, 0);
        chk("ar_Cnt", DW'(WbCount), 0);
        chk("ar_Last", DW'(WbLastReg), 0);
        tick();
        chk("ar_hold_Dbg", DbgData, 0);
        chk("ar_hold_Cnt", DW'(WbCount), 0);
        @(negedge clk);
        #1 rst_n = 1;
        tick();
        chk("ar_first_Dbg", DbgData, 32'hCAFE_0003);
        chk("ar_first_Cnt", DW'(WbCount), 1);
        chk("ar_first_Last", DW'(WbLastReg), 3);
        RegWriteW = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
